// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg
//   Shared constants for the CPU inter-stage pipeline registers.
//   - OCC_*       : occupancy encodings of the elastic stage (state encoding)
//   - *_W         : default packed bundle widths of the four stage registers
//   - PERF_CNT_W  : width of the optional performance counters
//   - sat_add     : saturating increment used by the performance counters
package cpu_pipe_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   localparam int unsigned IFID_W  = 96;
   localparam int unsigned IDEX_W  = 158;
   localparam int unsigned EXMEM_W = 120;
   localparam int unsigned MEMWB_W = 72;

   localparam int unsigned PERF_CNT_W = 32;

   // Adds a 0..3 increment and sticks at all-ones instead of wrapping.
   function automatic logic [PERF_CNT_W-1:0] sat_add(
      input logic [PERF_CNT_W-1:0] base,
      input logic [1:0]            inc
   );
      logic [PERF_CNT_W:0] sum;
      sum = {1'b0, base} + {{(PERF_CNT_W-1){1'b0}}, inc};
      if (sum[PERF_CNT_W])
         return '1;
      else
         return sum[PERF_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Generic two-entry elastic (main + skid) pipeline register carrying a
//   WIDTH-bit bundle under valid/ready. in_ready is a flop output so a
//   downstream stall never ripples combinationally upstream. Synchronous
//   flush turns all held entries into bubbles; bubble data reads as zero.
//
//   Optional feature macro: PIPE_STAGE_PERF_EN adds stall_cnt/squash_cnt.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears all state
//   flush      in   synchronous squash of all held entries
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage can accept (registered, == !skid_valid)
//   in_data    in   upstream bundle [WIDTH]
//   out_valid  out  main entry holds a valid bundle
//   out_ready  in   downstream accepts this cycle
//   out_data   out  bundle to next stage [WIDTH]
//   occupancy  out  held entries, 0..2
//   stall_cnt  out  (PIPE_STAGE_PERF_EN) cycles with out_valid & !out_ready
//   squash_cnt out  (PIPE_STAGE_PERF_EN) entries discarded by flush
module pipe_stage_elastic
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned WIDTH       = IDEX_W,
   parameter bit          ZERO_BUBBLE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
`ifdef PIPE_STAGE_PERF_EN
   output logic [1:0]            occupancy,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] squash_cnt
`else
   output logic [1:0]            occupancy
`endif
);

   logic [WIDTH-1:0] main_data, skid_data;
   logic             main_valid, skid_valid;

   logic [WIDTH-1:0] main_data_nxt, skid_data_nxt;
   logic             main_valid_nxt, skid_valid_nxt;

   logic             in_fire, out_fire;
   logic [1:0]       occ;

   // skid_valid implies main_valid, so the two flops fully encode the state.
   always_comb begin
      if (!main_valid)
         occ = OCC_EMPTY;
      else if (skid_valid)
         occ = OCC_FULL;
      else
         occ = OCC_ONE;
   end

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign occupancy = occ;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;

   assign out_data  = (ZERO_BUBBLE && !main_valid) ? '0 : main_data;

   // in_data is only routed into a register on in_fire, so X on an idle
   // bus never reaches state.
   always_comb begin
      main_data_nxt  = main_data;
      skid_data_nxt  = skid_data;
      main_valid_nxt = main_valid;
      skid_valid_nxt = skid_valid;

      if (flush) begin
         main_data_nxt  = '0;
         skid_data_nxt  = '0;
         main_valid_nxt = 1'b0;
         skid_valid_nxt = 1'b0;
      end else begin
         case (occ)
            OCC_EMPTY: begin
               if (in_fire) begin
                  main_data_nxt  = in_data;
                  main_valid_nxt = 1'b1;
               end
            end
            OCC_ONE: begin
               if (in_fire && out_fire) begin
                  main_data_nxt = in_data;
               end else if (in_fire) begin
                  skid_data_nxt  = in_data;
                  skid_valid_nxt = 1'b1;
               end else if (out_fire) begin
                  main_data_nxt  = '0;
                  main_valid_nxt = 1'b0;
               end
            end
            OCC_FULL: begin
               // in_ready is low here, so only the drain path exists.
               if (out_fire) begin
                  main_data_nxt  = skid_data;
                  skid_data_nxt  = '0;
                  skid_valid_nxt = 1'b0;
               end
            end
            default: begin
               main_data_nxt  = '0;
               skid_data_nxt  = '0;
               main_valid_nxt = 1'b0;
               skid_valid_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_data  <= '0;
         skid_data  <= '0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         main_data  <= main_data_nxt;
         skid_data  <= skid_data_nxt;
         main_valid <= main_valid_nxt;
         skid_valid <= skid_valid_nxt;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic stall;
   assign stall = main_valid & ~out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt  <= '0;
         squash_cnt <= '0;
      end else begin
         if (stall)
            stall_cnt <= sat_add(stall_cnt, 2'd1);
         if (flush)
            squash_cnt <= sat_add(squash_cnt, occ);
      end
   end
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, generic inter-stage pipeline register for the CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces hard-wired, fixed-width stage registers.
- Carries a WIDTH-bit packed control/data bundle under a valid/ready handshake.
- Two-entry elastic buffer (main + skid), so upstream ready is registered and stalls do not ripple combinationally.
- Synchronous flush squashes contents into bubbles. Bubble data reads as all-zero (NOP).

Parameters:
- WIDTH, 158, bits in the packed stage bundle.
- ZERO_BUBBLE, 1, 1: out_data forced to 0 when out_valid=0; 0: out_data shows the main register unmasked.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous squash of all held entries (branch/jump/exception).
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  block can accept; registered, equals !skid_valid.
- in_data  input  WIDTH  upstream bundle.
- out_valid  output  1  main entry holds a valid bundle.
- out_ready  input  1  downstream accepts this cycle (0 = stall).
- out_data  output  WIDTH  bundle to next stage.
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State encoded by occupancy:
  - EMPTY=0: main_valid=0, skid_valid=0.
  - ONE=1: main_valid=1.
  - FULL=2: main_valid=1, skid_valid=1.
- Reset (async, any time, including mid-transfer):
  - main, skid data = 0; both valid = 0.
  - occupancy=0, out_valid=0, in_ready=1, out_data=0.
  - Perf counters = 0.
- Transitions (registered, rising clk, when flush=0):
  - EMPTY, in_fire → ONE; main<=in_data. Latency in→out is exactly 1 cycle.
  - ONE, in_fire & out_fire → ONE; main<=in_data.
  - ONE, in_fire & !out_fire → FULL; skid<=in_data; in_ready drops the next cycle.
  - ONE, !in_fire & out_fire → EMPTY; main data cleared to 0.
  - FULL, out_fire → ONE; main<=skid; skid cleared to 0. in_ready=0 in FULL, so no in_fire can occur.
  - All other cases hold.
- Ordering is strictly FIFO: skid is never overtaken. No data is lost or duplicated under any valid/ready pattern.
- Flush has highest priority:
  - Next edge: both valids=0, both data regs=0, occupancy=0.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still completes downstream in that cycle.
- flush and reset are never both required to act at once; reset dominates.
- out_data = (ZERO_BUBBLE && !out_valid) ? 0 : main.
- in_data is sampled only on in_fire. X on in_data while in_valid=0 must not propagate.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN. When defined, two extra outputs are added:
  - stall_cnt[31:0]: increments each cycle out_valid & !out_ready.
  - squash_cnt[31:0]: increments by occupancy (0, 1 or 2) on each flush edge.
- Both counters saturate at 32'hFFFFFFFF and are cleared by reset only.
- When undefined, no counters or ports exist; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - occupancy localparams OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2.
  - default stage widths (e.g. IDEX_W=158).
  - the perf counter width constant PERF_CNT_W=32.
- No sub-module. Main and skid are two flat register banks in one module. Counters live inline under the macro.

Test Plan:
- Reset mid-FULL: load A=0x1, B=0x2 with out_ready=0, assert reset → same cycle occupancy=0, out_valid=0, out_data=0, in_ready=1.
- Streaming: out_ready=1, push 0x10..0x1F one per cycle → out_data sequence 0x10..0x1F, each 1 cycle after input, in_ready stays 1, occupancy stays ≤1.
- Backpressure: push 0xA, 0xB, 0xC with out_ready=0 → occupancy 1 then 2, in_ready=0 after 0xB, 0xC held upstream. Release out_ready → outputs 0xA, 0xB, 0xC in order, no loss or duplicate.
- Flush in FULL with in_valid=1 (data 0xD): next cycle occupancy=0, out_data=0, 0xD never appears. With PIPE_STAGE_PERF_EN, squash_cnt=2.
- Flush with out_fire: occupancy=1, out_ready=1, flush=1 → entry consumed that cycle, next cycle out_valid=0.
- Stall counting (PIPE_STAGE_PERF_EN): hold out_valid=1, out_ready=0 for 5 cycles → stall_cnt=5. With ZERO_BUBBLE=0 and empty stage, out_data shows the last cleared main value (0).
